fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction-fetch stage of the pipelined LEGv8 core: owns the program counter, drives the instruction-memory address and fills the IF/ID pipeline register consumed by the ID-stage control decoder. It is the other end of the decoder's branch interface. It takes the decoder's branch controls (taken, unconditional, register-branch) for the instruction currently in IF/ID, computes the target and redirects fetch with one architectural delay slot.

## Interface
- RESET_PC, 64'h0, PC value loaded on reset
- NOP_INSTR, 32'h0000_0000, instruction word placed in IF/ID when empty or squashed (decodes to the default no-op case)
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- stall  in  1  hazard stall; holds PC and IF/ID
- imem_addr  out  64  instruction address (equals PC register)
- imem_rdata  in  32  instruction word, combinational read of imem_addr
- br_taken  in  1  decoder BrTaken for IF/ID instruction
- uncond_br  in  1  decoder UncondBr: 1 selects imm26 (B/BL), 0 selects imm19 (CBZ/B.LT)
- br_reg  in  1  decoder BRSignal: jump to reg_target
- reg_target  in  64  register value for BR (forwarded Rd)
- ifid_instr  out  32  IF/ID instruction
- ifid_pc  out  64  IF/ID instruction address
- ifid_valid  out  1  IF/ID holds a real fetched instruction
- link_addr  out  64  ifid_pc + 4, value written to X30 by BL

## Operation
- Next-PC priority (stall=0): br_reg → reg_target; else br_taken → ifid_pc + (SE(offset) << 2); else pc + 4.
- offset = ifid_instr[25:0] when uncond_br=1, ifid_instr[23:5] when uncond_br=0; sign-extended to 64 bits, shifted left 2, added modulo 2^64 (negative offsets and address wrap are legal, no trap).
- Branch inputs apply only when ifid_valid=1; they are ignored when ifid_valid=0.
- Each non-stalled edge: ifid_instr←imem_rdata, ifid_pc←pc, ifid_valid←1, pc←next-PC.
- stall=1: pc, ifid_instr, ifid_pc, ifid_valid hold. Branch inputs are not acted on, and the decoder re-presents them after the stall.
- uncond_br is don't-care when br_taken=0. br_taken is don't-care when br_reg=1.

## Timing
- Reset (synchronous, dominates stall): pc=RESET_PC, ifid_instr=NOP_INSTR, ifid_pc=0, ifid_valid=0. link_addr therefore reads 4.
- First fetch at RESET_PC in the first cycle after reset deasserts. The first instruction reaches IF/ID one edge later.
- Branch resolution latency: branch in IF/ID in cycle n. The target is fetched in cycle n+1 and is in IF/ID after edge n+1.
- Delay slot: the instruction fetched in cycle n (pc = branch_pc + 4) enters IF/ID at edge n, regardless of branch outcome (see Configuration).
- Stall concurrent with a branch: the branch takes effect on the first non-stalled edge.
- Reset mid-branch or mid-stall: reset wins, and no redirect is retained.
- imem_addr is the registered PC only, with no combinational path from branch inputs.

## Configuration
- FETCH_SQUASH_EN defined: when a redirect is applied (br_reg, or br_taken with ifid_valid), the delay-slot instruction entering IF/ID at that edge is replaced by NOP_INSTR with ifid_valid=0. This gives zero-delay-slot semantics with a one-cycle bubble.
- Undefined: no squash, and the delay-slot instruction executes (baseline ISA behaviour of the core).

## Structure
- Shared package fetch_pkg: PC width (64), instruction width (32), NOP_INSTR constant, imm field bit ranges (IMM26 [25:0], IMM19 [23:5]).
- One sub-module: branch_target_calc (combinational: ifid_pc, ifid_instr, uncond_br → 64-bit target). The PC/IF-ID registers and next-PC mux stay in fetch_unit.

## Test plan
- Reset with RESET_PC=64'h100, stall=1 during reset → after release: imem_addr=0x100, ifid_valid=0, ifid_instr=0. With stall low, the next edge gives ifid_pc=0x100.
- Sequential fetch, no branches, 4 edges → imem_addr 0x100,0x104,0x108,0x10C. Each ifid_pc lags imem_addr by one cycle.
- B at 0x200 with imm26=-2 (br_taken=1, uncond_br=1) → next fetch 0x1F8. Delay slot 0x204 reaches IF/ID with ifid_valid=1, or with 0 when FETCH_SQUASH_EN is defined. Check link_addr=0x204 while B is in IF/ID.
- CBZ at 0x300 with imm19=+5, br_taken=1, uncond_br=0 → next fetch 0x314. Repeat with br_taken=0 → fetch 0x308.
- BR with reg_target=0xFFFF_FFFF_FFFF_FFFC, followed by sequential fetch → fetch 0xFFFF_FFFF_FFFF_FFFC, then 0x0 (wrap).
- B in IF/ID with stall held 3 cycles → PC and IF/ID frozen for 3 cycles. The redirect to the target occurs on the first edge after stall drops. Asserting reset during the stall returns pc to RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the LEGv8 instruction-fetch stage.
package fetch_pkg;

   localparam int unsigned PC_W      = 64;
   localparam int unsigned INSTR_W   = 32;
   localparam int unsigned IMM26_LSB = 0;
   localparam int unsigned IMM26_MSB = 25;
   localparam int unsigned IMM26_W   = IMM26_MSB - IMM26_LSB + 1;
   localparam int unsigned IMM19_LSB = 5;
   localparam int unsigned IMM19_MSB = 23;
   localparam int unsigned IMM19_W   = IMM19_MSB - IMM19_LSB + 1;
   localparam int unsigned WORD_SH   = 2;

   localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;
   localparam logic [PC_W-1:0]    PC_STEP   = 64'd4;

   // Source selected for the next program counter
   typedef enum logic [1:0] {
      NPC_SEQ    = 2'd0,
      NPC_BRANCH = 2'd1,
      NPC_REG    = 2'd2
   } npc_sel_e;

   // Contents of the IF/ID pipeline register
   typedef struct packed {
      logic [INSTR_W-1:0] instr;
      logic [PC_W-1:0]    pc;
      logic               valid;
   } ifid_t;

   // Sign-extended, word-scaled branch offset taken from the instruction immediate
   function automatic logic [PC_W-1:0] imm_to_offset(input logic [INSTR_W-1:0] instr,
                                                     input logic               uncond);
      logic [PC_W-1:0] off;
      if (uncond) begin
         off = {{(PC_W - IMM26_W - WORD_SH){instr[IMM26_MSB]}},
                instr[IMM26_MSB:IMM26_LSB], 2'b00};
      end else begin
         off = {{(PC_W - IMM19_W - WORD_SH){instr[IMM19_MSB]}},
                instr[IMM19_MSB:IMM19_LSB], 2'b00};
      end
      return off;
   endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: instruction memory port, decoder branch controls and IF/ID outputs.
interface fetch_unit_if;
   import fetch_pkg::*;

   logic                stall;
   logic [PC_W-1:0]     imem_addr;
   logic [INSTR_W-1:0]  imem_rdata;
   logic                br_taken;
   logic                uncond_br;
   logic                br_reg;
   logic [PC_W-1:0]     reg_target;
   logic [INSTR_W-1:0]  ifid_instr;
   logic [PC_W-1:0]     ifid_pc;
   logic                ifid_valid;
   logic [PC_W-1:0]     link_addr;

   // Fetch unit side
   modport master (
      input  stall, imem_rdata, br_taken, uncond_br, br_reg, reg_target,
      output imem_addr, ifid_instr, ifid_pc, ifid_valid, link_addr
   );

   // Memory / decoder / hazard-unit side
   modport slave (
      output stall, imem_rdata, br_taken, uncond_br, br_reg, reg_target,
      input  imem_addr, ifid_instr, ifid_pc, ifid_valid, link_addr
   );

endinterface

// File: rtl/fetch_unit_branch_target_calc.sv
// PC-relative branch target for the instruction held in IF/ID (combinational).
module branch_target_calc
   import fetch_pkg::*;
(
   input  logic [PC_W-1:0]    i_ifid_pc,
   input  logic [INSTR_W-1:0] i_ifid_instr,
   input  logic               i_uncond_br,
   output logic [PC_W-1:0]    o_target_c
);

   logic [PC_W-1:0] w_offset;

   // imm26 for B/BL, imm19 for conditional branches; add wraps modulo 2^64
   always_comb begin
      w_offset   = imm_to_offset(i_ifid_instr, i_uncond_br);
      o_target_c = i_ifid_pc + w_offset;
   end

endmodule

// File: rtl/fetch_unit.sv
// LEGv8 instruction-fetch stage: PC register, next-PC selection and IF/ID register.
// Optional build macro FETCH_SQUASH_EN: squash the delay-slot instruction on redirect.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [63:0] RESET_PC = 64'h0
)
(
   input  logic          clk,
   input  logic          reset,
   fetch_unit_if.master  bus
);

   logic [PC_W-1:0] r_pc;
   logic [PC_W-1:0] r_link_addr;
   ifid_t           r_ifid;

   npc_sel_e        w_npc_sel;
   logic [PC_W-1:0] w_br_target;
   logic [PC_W-1:0] w_next_pc;
   logic            w_squash;
   ifid_t           w_ifid_next;

   branch_target_calc u_btc (
      .i_ifid_pc    (r_ifid.pc),
      .i_ifid_instr (r_ifid.instr),
      .i_uncond_br  (bus.uncond_br),
      .o_target_c   (w_br_target)
   );

   // Choose the next-PC source; branch controls only count for a real IF/ID instruction
   always_comb begin
      w_npc_sel = NPC_SEQ;
      if (r_ifid.valid) begin
         if (bus.br_reg) begin
            w_npc_sel = NPC_REG;
         end else if (bus.br_taken) begin
            w_npc_sel = NPC_BRANCH;
         end
      end
   end

   // Next-PC mux
   always_comb begin
      w_next_pc = r_pc + PC_STEP;
      case (w_npc_sel)
         NPC_REG:    w_next_pc = bus.reg_target;
         NPC_BRANCH: w_next_pc = w_br_target;
         default:    w_next_pc = r_pc + PC_STEP;
      endcase
   end

   // Delay-slot handling on a redirect
   always_comb begin
`ifdef FETCH_SQUASH_EN
      w_squash = (w_npc_sel != NPC_SEQ);
`else
      w_squash = 1'b0;
`endif
   end

   // Value loaded into IF/ID on a non-stalled edge
   always_comb begin
      w_ifid_next.instr = bus.imem_rdata;
      w_ifid_next.pc    = r_pc;
      w_ifid_next.valid = 1'b1;
      if (w_squash) begin
         w_ifid_next.instr = NOP_INSTR;
         w_ifid_next.valid = 1'b0;
      end
   end

   // PC, IF/ID and link-address registers; reset dominates stall
   always_ff @(posedge clk) begin
      if (reset) begin
         r_pc         <= RESET_PC;
         r_ifid.instr <= NOP_INSTR;
         r_ifid.pc    <= '0;
         r_ifid.valid <= 1'b0;
         r_link_addr  <= PC_STEP;
      end else if (!bus.stall) begin
         r_pc        <= w_next_pc;
         r_ifid      <= w_ifid_next;
         r_link_addr <= r_pc + PC_STEP;
      end
   end

   // Outputs come straight from registers
   always_comb begin
      bus.imem_addr  = r_pc;
      bus.ifid_instr = r_ifid.instr;
      bus.ifid_pc    = r_ifid.pc;
      bus.ifid_valid = r_ifid.valid;
      bus.link_addr  = r_link_addr;
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed vectors push expected post-edge state,
// a monitor pops and compares after every clock edge.
module tb_fetch_unit;

`ifdef FETCH_SQUASH_EN
   localparam logic DS = 1'b0;
`else
   localparam logic DS = 1'b1;
`endif

   typedef struct {
      logic [63:0] pc;
      logic [63:0] ifid_pc;
      logic [31:0] instr;
      logic        valid;
      logic [63:0] link;
   } exp_t;

   logic clk;
   logic reset;
   int   checks;
   int   errors;
   int   vec_id;
   exp_t exp_q[$];

   fetch_unit_if bus();

   fetch_unit #(.RESET_PC(64'h100)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Instruction memory image: B imm26=-2 at 0x200, CBZ imm19=+5 at 0x300, filler elsewhere
   function automatic logic [31:0] instr_at(input logic [63:0] a);
      logic [31:0] w;
      case (a)
         64'h200: w = {6'b000101, 26'h3FF_FFFE};
         64'h300: w = {8'b1011_0100, 19'd5, 5'd0};
         default: w = 32'h8B00_0000 ^ a[31:0];
      endcase
      return w;
   endfunction

   assign bus.imem_rdata = instr_at(bus.imem_addr);

   task automatic step(input logic rst, input logic st, input logic bt, input logic ub,
                       input logic brr, input logic [63:0] rt,
                       input logic [63:0] e_pc, input logic [63:0] e_ifpc, input logic e_v);
      exp_t e;
      @(negedge clk);
      reset          = rst;
      bus.stall      = st;
      bus.br_taken   = bt;
      bus.uncond_br  = ub;
      bus.br_reg     = brr;
      bus.reg_target = rt;
      e.pc      = e_pc;
      e.ifid_pc = e_ifpc;
      e.valid   = e_v;
      e.instr   = e_v ? instr_at(e_ifpc) : 32'h0;
      e.link    = e_ifpc + 64'd4;
      exp_q.push_back(e);
   endtask

   task automatic idle(input logic [63:0] e_pc, input logic [63:0] e_ifpc);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0, e_pc, e_ifpc, 1'b1);
   endtask

   task automatic jump_reg(input logic [63:0] rt, input logic [63:0] e_ifpc);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, rt, rt, e_ifpc, DS);
   endtask

   // Monitor: compare the state presented after each edge with the oldest expectation
   initial begin
      exp_t e;
      vec_id = 0;
      forever begin
         @(posedge clk);
         #2;
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checks++;
            if (bus.imem_addr !== e.pc || bus.ifid_pc !== e.ifid_pc ||
                bus.ifid_instr !== e.instr || bus.ifid_valid !== e.valid ||
                bus.link_addr !== e.link) begin
               errors++;
               $display("FAIL vec%0d got pc=%h ifpc=%h instr=%h v=%b link=%h exp pc=%h ifpc=%h instr=%h v=%b link=%h",
                        vec_id, bus.imem_addr, bus.ifid_pc, bus.ifid_instr, bus.ifid_valid,
                        bus.link_addr, e.pc, e.ifid_pc, e.instr, e.valid, e.link);
            end
            vec_id++;
         end
      end
   end

   // Stimulus
   initial begin
      checks = 0;
      errors = 0;
      reset = 1'b1;
      bus.stall = 1'b1;
      bus.br_taken = 1'b0;
      bus.uncond_br = 1'b0;
      bus.br_reg = 1'b0;
      bus.reg_target = 64'h0;

      // Reset with stall high, then release while still stalled
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 64'h0, 64'h100, 64'h0, 1'b0);
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 64'h0, 64'h100, 64'h0, 1'b0);
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 64'h0, 64'h100, 64'h0, 1'b0);

      // Sequential fetch
      idle(64'h104, 64'h100);
      idle(64'h108, 64'h104);
      idle(64'h10C, 64'h108);
      idle(64'h110, 64'h10C);

      // B at 0x200, imm26 = -2 -> 0x1F8; link 0x204 while B sits in IF/ID
      jump_reg(64'h200, 64'h110);
      idle(64'h204, 64'h200);
      step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 64'h0, 64'h1F8, 64'h204, DS);
      idle(64'h1FC, 64'h1F8);

      // CBZ at 0x300, imm19 = +5, taken -> 0x314
      jump_reg(64'h300, 64'h1FC);
      idle(64'h304, 64'h300);
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 64'h0, 64'h314, 64'h304, DS);

      // Same CBZ not taken -> 0x308
      jump_reg(64'h300, 64'h314);
      idle(64'h304, 64'h300);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 64'h308, 64'h304, 1'b1);

      // BR to top of address space, then sequential wrap to 0
      jump_reg(64'hFFFF_FFFF_FFFF_FFFC, 64'h308);
      idle(64'h0, 64'hFFFF_FFFF_FFFF_FFFC);
      idle(64'h4, 64'h0);

      // br_reg has priority over br_taken
      jump_reg(64'h200, 64'h4);
      idle(64'h204, 64'h200);
      step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 64'h600, 64'h600, 64'h204, DS);
      idle(64'h604, 64'h600);

      // B in IF/ID under a 3-cycle stall, redirect on first free edge
      jump_reg(64'h200, 64'h604);
      idle(64'h204, 64'h200);
      step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 64'h0, 64'h204, 64'h200, 1'b1);
      step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 64'h0, 64'h204, 64'h200, 1'b1);
      step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 64'h0, 64'h204, 64'h200, 1'b1);
      step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 64'h0, 64'h1F8, 64'h204, DS);
      idle(64'h1FC, 64'h1F8);

      // Reset during a stalled branch drops the redirect
      jump_reg(64'h200, 64'h1FC);
      idle(64'h204, 64'h200);
      step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 64'h0, 64'h204, 64'h200, 1'b1);
      step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 64'h0, 64'h100, 64'h0, 1'b0);

      // Branch controls ignored while IF/ID is empty
      step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 64'h500, 64'h104, 64'h100, 1'b1);
      idle(64'h108, 64'h104);

      // Drain the scoreboard with a bounded wait
      for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
      #5;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
